// File: rtl/max_min_reduce_nbit.sv
// Streaming max/min reduction over a valid/ready packet stream.
// Returns the extreme element, its index and the beat count once in_last is seen.
module max_min_reduce_nbit #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CNT_WIDTH = 8,
    parameter bit          IS_SIGNED = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode_min,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CNT_WIDTH-1:0] out_idx,
    output logic [CNT_WIDTH:0]   out_count,
    output logic                 out_ovf
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    // Flipping the MSB maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0]   KEY_FLIP = IS_SIGNED ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
    localparam logic [CNT_WIDTH:0] CNT_ONE  = {{CNT_WIDTH{1'b0}}, 1'b1};

    state_t                 state;
    logic [WIDTH-1:0]       acc;
    logic [CNT_WIDTH-1:0]   idx;
    logic [CNT_WIDTH:0]     cnt;
    logic                   ovf;
    logic                   mode_q;

    logic                   accept;
    logic [WIDTH-1:0]       key_new;
    logic [WIDTH-1:0]       key_acc;
    logic                   better;
    logic [CNT_WIDTH-1:0]   beat_idx;
    logic [WIDTH-1:0]       n_acc;
    logic [CNT_WIDTH-1:0]   n_idx;
    logic [CNT_WIDTH:0]     n_cnt;
    logic                   n_ovf;

    // Next accumulator values for the beat currently offered on the input.
    always_comb begin
        accept   = in_valid && in_ready;
        key_new  = in_data ^ KEY_FLIP;
        key_acc  = acc ^ KEY_FLIP;
        better   = mode_q ? (key_new < key_acc) : (key_new > key_acc);
        // Once the count has saturated, the index sticks at its largest value.
        beat_idx = cnt[CNT_WIDTH] ? '1 : cnt[CNT_WIDTH-1:0];
        n_acc    = acc;
        n_idx    = idx;
        n_cnt    = cnt;
        n_ovf    = ovf;
        if (state == IDLE) begin
            n_acc = in_data;
            n_idx = '0;
            n_cnt = CNT_ONE;
            n_ovf = 1'b0;
        end else begin
            if (better) begin
                n_acc = in_data;
                n_idx = beat_idx;
            end
            n_cnt = cnt[CNT_WIDTH] ? cnt : cnt + CNT_ONE;
            n_ovf = ovf | cnt[CNT_WIDTH];
        end
    end

    // Packet FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            idx       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            mode_q    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        acc <= n_acc;
                        idx <= n_idx;
                        cnt <= n_cnt;
                        ovf <= n_ovf;
                        if (state == IDLE) begin
                            mode_q  <= mode_min;
                            out_ovf <= 1'b0;
                        end
                        if (in_last) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_data  <= n_acc;
                            out_idx   <= n_idx;
                            out_count <= n_cnt;
                            out_ovf   <= n_ovf;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max_min_reduce_nbit.sv
// Scoreboard bench: three DUT variants share one input stream; a reference
// model predicts each variant's result and a monitor checks every output.
module tb_max_min_reduce_nbit;

    typedef struct {
        logic [15:0] data;
        int          idx;
        int          count;
        bit          ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst, mode_min, in_valid, in_last, out_ready;
    logic [15:0] in_data;

    logic        r0, v0, o0, r1, v1, o1, r2, v2, o2;
    logic [15:0] d0, d1, d2;
    logic [7:0]  i0, i1;
    logic [8:0]  c0, c1;
    logic [1:0]  i2;
    logic [2:0]  c2;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   hold_until = 0;
    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;

    always #5 clk = ~clk;

    max_min_reduce_nbit #(.WIDTH(16), .CNT_WIDTH(8), .IS_SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .mode_min(mode_min), .in_valid(in_valid), .in_ready(r0),
        .in_data(in_data), .in_last(in_last), .out_valid(v0), .out_ready(out_ready),
        .out_data(d0), .out_idx(i0), .out_count(c0), .out_ovf(o0));

    max_min_reduce_nbit #(.WIDTH(16), .CNT_WIDTH(8), .IS_SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .mode_min(mode_min), .in_valid(in_valid), .in_ready(r1),
        .in_data(in_data), .in_last(in_last), .out_valid(v1), .out_ready(out_ready),
        .out_data(d1), .out_idx(i1), .out_count(c1), .out_ovf(o1));

    max_min_reduce_nbit #(.WIDTH(16), .CNT_WIDTH(2), .IS_SIGNED(1'b1)) dut_c (
        .clk(clk), .rst(rst), .mode_min(mode_min), .in_valid(in_valid), .in_ready(r2),
        .in_data(in_data), .in_last(in_last), .out_valid(v2), .out_ready(out_ready),
        .out_data(d2), .out_idx(i2), .out_count(c2), .out_ovf(o2));

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream: random back-pressure, forced low until hold_until.
    always @(posedge clk) begin
        #1;
        if (rst) out_ready = 1'b0;
        else if (cyc < hold_until) out_ready = 1'b0;
        else out_ready = ($urandom_range(3) != 0);
    end

    task automatic cmp(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: extreme value by integer comparison, first occurrence wins.
    function automatic exp_t model(input logic [15:0] p[$], input bit mn, input bit sgn,
                                   input int cw);
        exp_t   e;
        longint best, v;
        int     bi;
        int     lim;
        lim  = 1 << cw;
        best = sgn ? longint'($signed(p[0])) : longint'(p[0]);
        bi   = 0;
        for (int i = 1; i < p.size(); i++) begin
            v = sgn ? longint'($signed(p[i])) : longint'(p[i]);
            if (mn ? (v < best) : (v > best)) begin
                best = v;
                bi   = i;
            end
        end
        e.data  = p[bi];
        e.idx   = (bi > lim - 1) ? lim - 1 : bi;
        e.count = (p.size() > lim) ? lim : p.size();
        e.ovf   = (p.size() > lim);
        return e;
    endfunction

    task automatic mon(input string nm, input int has, input exp_t e, input logic v,
                       input logic r, input logic [15:0] d, input int idx, input int cnt,
                       input logic ovf);
        if (v) begin
            if (has == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL %s_unexpected: got out_valid 1 expected no pending result", nm);
            end else begin
                cmp({nm, "_data"}, longint'(d), longint'(e.data));
                cmp({nm, "_idx"}, idx, e.idx);
                cmp({nm, "_count"}, cnt, e.count);
                cmp({nm, "_ovf"}, longint'(ovf), longint'(e.ovf));
                cmp({nm, "_in_ready_hold"}, longint'(r), 0);
            end
        end
    endtask

    // Monitor: compares whatever the DUTs present against the queue heads.
    always @(negedge clk) begin
        if (!rst) begin
            e0 = (q0.size() > 0) ? q0[0] : e0;
            e1 = (q1.size() > 0) ? q1[0] : e1;
            e2 = (q2.size() > 0) ? q2[0] : e2;
            mon("s8", q0.size(), e0, v0, r0, d0, int'(i0), int'(c0), o0);
            mon("u8", q1.size(), e1, v1, r1, d1, int'(i1), int'(c1), o1);
            mon("s2", q2.size(), e2, v2, r2, d2, int'(i2), int'(c2), o2);
            if (v0 && out_ready && q0.size() > 0) void'(q0.pop_front());
            if (v1 && out_ready && q1.size() > 0) void'(q1.pop_front());
            if (v2 && out_ready && q2.size() > 0) void'(q2.pop_front());
        end
    end

    // Called at posedge+1; leaves at posedge+1.
    task automatic send_pkt(input logic [15:0] p[$], input bit mn, input int gap_pct,
                            input bit toggle, input bit with_last);
        int t;
        if (with_last) begin
            q0.push_back(model(p, mn, 1'b1, 8));
            q1.push_back(model(p, mn, 1'b0, 8));
            q2.push_back(model(p, mn, 1'b1, 2));
        end
        for (int i = 0; i < p.size(); i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                if (toggle) mode_min = $urandom_range(1);
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = p[i];
            in_last  = with_last && (i == p.size() - 1);
            mode_min = (i == 0 || !toggle) ? mn : 1'($urandom_range(1));
            t = 0;
            forever begin
                @(negedge clk);
                if (r0) break;
                t++;
                if (t > 200) begin
                    $display("FAIL accept_timeout: got no in_ready expected in_ready within 200 cycles");
                    $fatal(1);
                end
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (in_last) begin
                in_last = 1'b0;
                @(negedge clk);
                cmp("latency_out_valid", longint'(v0), 1);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("rst_in_ready", longint'({r0, r1, r2}), 0);
        cmp("rst_out_valid", longint'({v0, v1, v2}), 0);
        cmp("rst_out_data", longint'(d0 | d1 | d2), 0);
        cmp("rst_out_idx", longint'(i0 | i1 | 8'(i2)), 0);
        cmp("rst_out_count", longint'(c0 | c1 | 9'(c2)), 0);
        cmp("rst_out_ovf", longint'({o0, o1, o2}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmp("post_rst_in_ready", longint'({r0, r1, r2}), 7);
        cmp("post_rst_out_valid", longint'({v0, v1, v2}), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] p[$];
        int t;
        rst = 1'b1;
        mode_min = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        @(posedge clk);
        #1;
        do_reset();

        p = '{16'd5, 16'hFFFD, 16'h7FFF, 16'd12, 16'h7FFF};
        send_pkt(p, 1'b0, 0, 1'b0, 1'b1);

        p = '{16'h0001, 16'h8000, 16'hFFFF};
        send_pkt(p, 1'b1, 0, 1'b0, 1'b1);
        send_pkt(p, 1'b0, 0, 1'b0, 1'b1);

        hold_until = cyc + 7;
        p = '{16'h1234};
        send_pkt(p, 1'b0, 0, 1'b0, 1'b1);

        p = '{16'd7, 16'd9, 16'd3};
        send_pkt(p, 1'b0, 50, 1'b1, 1'b1);

        p = '{16'd3, 16'd1, 16'd4, 16'd1, 16'd5, 16'd9};
        send_pkt(p, 1'b0, 0, 1'b0, 1'b1);
        p = '{16'd2, 16'd6};
        send_pkt(p, 1'b0, 0, 1'b0, 1'b1);

        p = '{16'd1, 16'd2, 16'd3};
        send_pkt(p, 1'b0, 0, 1'b0, 1'b0);
        do_reset();

        hold_until = cyc + 1000;
        p = '{16'd10, 16'd20};
        send_pkt(p, 1'b0, 0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        hold_until = 0;
        repeat (3) @(negedge clk) cmp("aborted_no_valid", longint'({v0, v1, v2}), 0);
        @(posedge clk);
        #1;

        p = '{16'd4, 16'd8};
        send_pkt(p, 1'b0, 0, 1'b0, 1'b1);

        for (int k = 0; k < 40; k++) begin
            p.delete();
            for (int j = 0; j < int'($urandom_range(1, 9)); j++) begin
                p.push_back(($urandom_range(3) == 0) ? 16'(p.size() % 3) : 16'($urandom));
            end
            send_pkt(p, 1'($urandom_range(1)), 30, 1'b1, 1'b1);
        end

        t = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        vectors++;
        if ((q0.size() + q1.size() + q2.size()) != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending results expected 0",
                     q0.size() + q1.size() + q2.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
